// File: rtl/tick_scheduler.sv
// tick_scheduler: programmable multi-channel tick generator.
// Each channel produces a one-cycle enable strobe every div_eff cycles while
// enabled and not paused. A valid/ready config port rewrites one channel's
// period and enable per accepted request.
module tick_scheduler #(
  parameter int               NCH     = 4,
  parameter int               CW      = 22,
  parameter int unsigned      DEF_DIV = 2097152,
  parameter logic [NCH-1:0]   EN_RST  = NCH'(1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [2:0]     cfg_ch,
  input  logic [CW-1:0]  cfg_div,
  input  logic           cfg_en,
  input  logic           pause,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] active
);

  localparam logic [CW-1:0] DEF_DIV_W = CW'(DEF_DIV);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t state;
  state_t state_next;
  logic   accept;

  assign accept = cfg_valid & cfg_ready;

  // Config FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Ready in IDLE; one HOLD cycle after every accepted request.
  always_comb begin
    state_next = state;
    cfg_ready  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_next = HOLD;
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] cnt;
      logic [CW-1:0] div;
      logic [CW-1:0] div_eff;
      logic          en;
      logic          run;
      logic          wr;
      logic          tick_q;
      logic          active_q;

      // Full 3-bit compare so out-of-range channel indices hit nothing.
      assign wr      = accept && (cfg_ch == 3'(gi));
      assign div_eff = (div < CW'(2)) ? CW'(1) : div;
      assign run     = en & ~pause;

      // Channel counter: a config write takes priority over counting and
      // clears the count, which also keeps cnt below a newly lowered period.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt    <= '0;
          div    <= DEF_DIV_W;
          en     <= EN_RST[gi];
          tick_q <= 1'b0;
        end else if (wr) begin
          cnt    <= '0;
          div    <= cfg_div;
          en     <= cfg_en;
          tick_q <= 1'b0;
        end else if (run && (cnt == div_eff - CW'(1))) begin
          cnt    <= '0;
          tick_q <= 1'b1;
        end else if (run) begin
          cnt    <= cnt + CW'(1);
          tick_q <= 1'b0;
        end else begin
          tick_q <= 1'b0;
        end
      end

      // Registered run status, one cycle behind en/pause.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) active_q <= 1'b0;
        else      active_q <= en & ~pause;
      end

      assign tick[gi]   = tick_q;
      assign active[gi] = active_q;
    end
  endgenerate

endmodule
